// File: rtl/fp_align_pipe.sv
// Two-stage operand aligner for the FP adder: orders A/B by magnitude, then
// right-aligns the smaller mantissa by the exponent difference with a sticky bit.
module fp_align_pipe #(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 28,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic             op_sub_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sw_o,
  output logic             sign_o,
  output logic             eff_sub_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [EXP_W-1:0] exp_diff_o,
  output logic [MAN_W-1:0] big_man_o,
  output logic [MAN_W-1:0] small_man_o
);

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // Handshake: a stage transfers on valid & ready at the same rising edge; a
  // stage advances when it is empty or its successor advances, so a full pipe
  // with out_ready=1 accepts a new pair every cycle. Held data never changes.
  logic s1_adv, s2_adv;
  logic v1_q, v2_q;

  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: magnitude compare and swap
  logic [EXP_W-1:0] ee_a, ee_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             swap;
  logic             sw1_d, sign1_d, eff1_d;
  logic [EXP_W-1:0] exp1_d, diff1_d;
  logic [MAN_W-1:0] big1_d, small1_d;

  always_comb begin
    man_a    = a_i[MAN_W-1:0];
    man_b    = b_i[MAN_W-1:0];
    // Subnormals align as if their exponent were 1.
    ee_a     = (a_i[W-2:MAN_W] == '0) ? EXP_ONE : a_i[W-2:MAN_W];
    ee_b     = (b_i[W-2:MAN_W] == '0) ? EXP_ONE : b_i[W-2:MAN_W];
    swap     = (ee_b > ee_a) || ((ee_b == ee_a) && (man_b > man_a));
    sw1_d    = swap;
    sign1_d  = swap ? (b_i[W-1] ^ op_sub_i) : a_i[W-1];
    eff1_d   = a_i[W-1] ^ b_i[W-1] ^ op_sub_i;
    exp1_d   = swap ? ee_b : ee_a;
    diff1_d  = swap ? (ee_b - ee_a) : (ee_a - ee_b);
    big1_d   = swap ? man_b : man_a;
    small1_d = swap ? man_a : man_b;
  end

  logic             sw1_q, sign1_q, eff1_q;
  logic [EXP_W-1:0] exp1_q, diff1_q;
  logic [MAN_W-1:0] big1_q, small1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      sw1_q    <= 1'b0;
      sign1_q  <= 1'b0;
      eff1_q   <= 1'b0;
      exp1_q   <= '0;
      diff1_q  <= '0;
      big1_q   <= '0;
      small1_q <= '0;
    end else begin
      if (s1_adv) v1_q <= in_valid;
      if (s1_adv && in_valid) begin
        sw1_q    <= sw1_d;
        sign1_q  <= sign1_d;
        eff1_q   <= eff1_d;
        exp1_q   <= exp1_d;
        diff1_q  <= diff1_d;
        big1_q   <= big1_d;
        small1_q <= small1_d;
      end
    end
  end

  // Stage 2: alignment shift with sticky collection
  logic [MAN_W-1:0] shifted, lost_mask, small2_d;
  logic             sticky;

  always_comb begin
    shifted   = small1_q >> diff1_q;
    lost_mask = ~({MAN_W{1'b1}} << diff1_q);
    sticky    = |(small1_q & lost_mask);
    if (32'(diff1_q) >= 32'(MAN_W))
      small2_d = {{(MAN_W-1){1'b0}}, |small1_q};
    else
      small2_d = shifted | {{(MAN_W-1){1'b0}}, sticky};
  end

  logic             sw2_q, sign2_q, eff2_q;
  logic [EXP_W-1:0] exp2_q, diff2_q;
  logic [MAN_W-1:0] big2_q, small2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      sw2_q    <= 1'b0;
      sign2_q  <= 1'b0;
      eff2_q   <= 1'b0;
      exp2_q   <= '0;
      diff2_q  <= '0;
      big2_q   <= '0;
      small2_q <= '0;
    end else begin
      if (s2_adv) v2_q <= v1_q;
      if (s2_adv && v1_q) begin
        sw2_q    <= sw1_q;
        sign2_q  <= sign1_q;
        eff2_q   <= eff1_q;
        exp2_q   <= exp1_q;
        diff2_q  <= diff1_q;
        big2_q   <= big1_q;
        small2_q <= small2_d;
      end
    end
  end

  assign out_valid   = v2_q;
  assign sw_o        = sw2_q;
  assign sign_o      = sign2_q;
  assign eff_sub_o   = eff2_q;
  assign exp_o       = exp2_q;
  assign exp_diff_o  = diff2_q;
  assign big_man_o   = big2_q;
  assign small_man_o = small2_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Randomized scoreboard bench for fp_align_pipe with directed corner cases,
// backpressure, mid-flight reset and a magnitude-based reference model.
module tb_fp_align_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 28;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = 3 + 2 * EXP_W + 2 * MAN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a_i = '0;
  logic [W-1:0]     b_i = '0;
  logic             op_sub_i = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             sw_o, sign_o, eff_sub_o;
  logic [EXP_W-1:0] exp_o, exp_diff_o;
  logic [MAN_W-1:0] big_man_o, small_man_o;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .op_sub_i(op_sub_i), .out_valid(out_valid),
    .out_ready(out_ready), .sw_o(sw_o), .sign_o(sign_o), .eff_sub_o(eff_sub_o),
    .exp_o(exp_o), .exp_diff_o(exp_diff_o), .big_man_o(big_man_o),
    .small_man_o(small_man_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] act;
  assign act = {sw_o, sign_o, eff_sub_o, exp_o, exp_diff_o, big_man_o, small_man_o};

  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  int            checks = 0;
  int            errors = 0;
  int            accepted = 0;
  bit            lat_chk = 1'b0;
  bit            rnd_or = 1'b0;

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: order by value ee*2^MAN_W + man, align by integer division.
  function automatic logic [EW-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic op);
    longint ea, eb, ma, mb, eb_big, es, mbig, ms, d, p, sm;
    bit     swp, sgn, eff;
    ea = longint'(a[W-2:MAN_W]);
    eb = longint'(b[W-2:MAN_W]);
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    ma = longint'(a[MAN_W-1:0]);
    mb = longint'(b[MAN_W-1:0]);
    swp = (eb * 268435456 + mb) > (ea * 268435456 + ma);
    eb_big = swp ? eb : ea;
    es     = swp ? ea : eb;
    mbig   = swp ? mb : ma;
    ms     = swp ? ma : mb;
    d      = eb_big - es;
    if (d >= MAN_W) begin
      sm = (ms != 0) ? 1 : 0;
    end else begin
      p  = longint'(1) << d;
      sm = ms / p;
      if ((ms % p) != 0) sm = sm | 1;
    end
    sgn = swp ? (b[W-1] ^ op) : a[W-1];
    eff = a[W-1] ^ b[W-1] ^ op;
    return {swp, sgn, eff, EXP_W'(eb_big), EXP_W'(d), MAN_W'(mbig), MAN_W'(sm)};
  endfunction

  // driver: offer one pair until accepted, push its expected result
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic [EW-1:0] e);
    int n = 0;
    @(negedge clk);
    a_i = a; b_i = b; op_sub_i = op; in_valid = 1'b1;
    forever begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        accepted++;
        @(posedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    drive(a, b, op, ref_model(a, b, op));
  endtask

  function automatic logic [W-1:0] mk(input logic s, input logic [EXP_W-1:0] e,
                                      input logic [MAN_W-1:0] m);
    return {s, e, m};
  endfunction

  // monitor: pop and compare whenever a result is transferred
  logic [EW-1:0] held;
  bit            stalled = 1'b0;
  initial begin
    logic [EW-1:0] e;
    int            c;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && out_valid) check("hold_stable", act, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output got=%h want=none", act);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("result", act, e);
            if (lat_chk) check("latency", EW'(cyc - c), EW'(2));
          end
        end
        stalled = out_valid && !out_ready;
        held    = act;
      end
    end
  end

  always @(negedge clk) if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);

  function automatic logic [W-1:0] rnd_operand(input int ebase, input int mode);
    int             e;
    logic [MAN_W-1:0] m;
    e = ebase;
    case (mode)
      0: e = $urandom_range(0, 255);
      1: e = ebase;
      2: begin
        e = ebase + $urandom_range(0, 70) - 35;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
      end
      default: e = $urandom_range(0, 2);
    endcase
    m = MAN_W'($urandom());
    if ($urandom_range(0, 3) == 0) m = m & MAN_W'(32'h0000_00FF);
    return {1'($urandom_range(0, 1)), EXP_W'(e), m};
  endfunction

  initial begin
    int base;
    int ea;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", EW'(out_valid), 0);
    check("rst_fields", act, 0);
    check("rst_in_ready", EW'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    lat_chk = 1'b1;

    // directed cases with spelled-out expectations
    drive(mk(0, 8'h82, 28'h8000000), mk(0, 8'h80, 28'hC000001), 1'b0,
          {1'b0, 1'b0, 1'b0, 8'h82, 8'd2, 28'h8000000, 28'h3000001});
    drive(mk(0, 8'h00, 28'h0000010), mk(1, 8'h7F, 28'h8000000), 1'b1,
          {1'b1, 1'b0, 1'b0, 8'h7F, 8'd126, 28'h8000000, 28'h0000001});
    drive(mk(0, 8'h90, 28'h9000000), mk(0, 8'h90, 28'hA000000), 1'b0,
          {1'b1, 1'b0, 1'b0, 8'h90, 8'd0, 28'hA000000, 28'h9000000});
    drive(mk(1, 8'h45, 28'hABCDEF0), mk(1, 8'h45, 28'hABCDEF0), 1'b1,
          {1'b0, 1'b1, 1'b1, 8'h45, 8'd0, 28'hABCDEF0, 28'hABCDEF0});
    send(mk(0, 8'h40, 28'hFFFFFFF), mk(0, 8'h24, 28'hFFFFFFF), 1'b0);
    send(mk(0, 8'h40, 28'h0000001), mk(0, 8'h25, 28'hFFFFFFF), 1'b0);
    send(mk(0, 8'hFF, 28'h0000000), mk(1, 8'h01, 28'h8000000), 1'b0);
    repeat (4) @(negedge clk);

    // backpressure: out_ready low for 4 cycles, 3 pairs offered back-to-back
    lat_chk = 1'b0;
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(rnd_operand(0, 0), rnd_operand(0, 0), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(negedge clk);
        #3;
        check("bp_accepted", EW'(accepted - base), 2);
        check("bp_in_ready", EW'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          #3;
          check("bp_no_gap", EW'(out_valid), 1);
          @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);

    // reset with two pairs in flight
    out_ready = 1'b0;
    send(rnd_operand(0, 0), rnd_operand(0, 0), 1'b0);
    send(rnd_operand(0, 0), rnd_operand(0, 0), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    check("mid_rst_out_valid", EW'(out_valid), 0);
    check("mid_rst_fields", act, 0);
    check("mid_rst_in_ready", EW'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("post_rst_idle", EW'(out_valid), 0);
      @(negedge clk);
    end
    lat_chk = 1'b1;
    send(mk(0, 8'h10, 28'h8000003), mk(1, 8'h12, 28'h8000000), 1'b0);
    repeat (4) @(negedge clk);

    // randomized traffic with random backpressure
    lat_chk = 1'b0;
    rnd_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ea = $urandom_range(0, 255);
      ra = rnd_operand(ea, 1);
      rb = rnd_operand(ea, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 1) == 0) send(ra, rb, 1'($urandom_range(0, 1)));
      else send(rb, ra, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
    rnd_or = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", EW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined successor to the FPU adder-subtractor operand comparator/swapper.
- Orders the two operands by magnitude, not only by subnormal status.
- Computes the exponent difference and right-aligns the smaller mantissa with a sticky bit.
- Sits between operand unpack and the mantissa add/sub stage; valid/ready on both sides, 2-cycle latency, 1 op/cycle throughput.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 28, mantissa field width, including hidden bit at [MAN_W-1] and GRS bits at [2:0].
W, 1+EXP_W+MAN_W (37), operand width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept the pair this cycle.
a_i  in  W  operand A: [W-1] sign, [W-2:MAN_W] exp, [MAN_W-1:0] mantissa.
b_i  in  W  operand B, same format.
op_sub_i  in  1  1 = A-B, 0 = A+B.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
sw_o  out  1  1 = operands were swapped (B is larger).
sign_o  out  1  sign of larger operand (B's sign XOR op_sub when swapped).
eff_sub_o  out  1  effective subtraction: sA ^ sB ^ op_sub.
exp_o  out  EXP_W  effective exponent of larger operand.
exp_diff_o  out  EXP_W  effective exponent difference, unsaturated.
big_man_o  out  MAN_W  mantissa of larger operand.
small_man_o  out  MAN_W  aligned mantissa of smaller operand, sticky ORed into bit 0.

Behaviour:
- Effective exponent: ee = (E==0) ? 1 : E. Subnormals align as exponent 1.
- Mantissa fields pass through unmodified. The block does not insert the hidden bit.
- Stage 1 (compare), registered:
  - swap = (eeB > eeA) | (eeB == eeA & manB > manA). Ties do not swap.
  - Capture big/small, sw, sign, eff_sub.
  - diff = ee_big - ee_small. Always >= 0; no wrap.
- Stage 2 (align), registered:
  - shift small mantissa right by min(diff, MAN_W).
  - sticky = OR of all bits shifted out.
  - small_man_o = shifted | {0..,sticky}.
  - diff >= MAN_W: small_man_o = {0.., |man_small}.
  - diff == 0: small mantissa unchanged.
- Handshake:
  - s2_adv = !v2 | out_ready.
  - s1_adv = !v1 | s2_adv.
  - in_ready = s1_adv (combinational).
  - Transfer occurs on valid & ready at the same edge.
  - Stage data is held stable while its valid is high and it is not advancing.
  - out_valid = v2. Output fields are stable while out_valid & !out_ready.
- Latency: an accepted pair appears on out_valid exactly 2 cycles later if out_ready stays high.
- Ordering and loss: results exit in acceptance order; none lost or duplicated.
- Reset:
  - rst_n low clears v1, v2 and all data registers to 0 immediately.
  - All outputs read 0 and in_ready reads 1 while in reset.
  - Reset mid-operation discards in-flight pairs.
  - After release, the first accepted input produces the first output.
- Simultaneous accept and drain: with both stages full and out_ready=1, a new input is accepted in the same cycle; throughput stays 1/cycle.
- The block ignores NaN/Inf (all-ones exponent) and treats them as ordinary large numbers; the special-case path handles them elsewhere.

Test Plan:
- A = {0,0x82,0x8000000}, B = {0,0x80,0xC000001}, add, out_ready=1 -> 2 cycles later:
  - sw=0, exp_o=0x82, diff=2
  - big=0x8000000, small=0x3000001 (sticky from shifted-out 01)
  - eff_sub=0
- A = {0,0x00,0x0000010} (subnormal), B = {1,0x7F,0x8000000}, sub -> sw=1, exp_o=0x7F, diff=126, small=0x0000001, sign_o=0, eff_sub=0.
- Equal exponents 0x90, manA=0x9000000, manB=0xA000000 -> sw=1, diff=0, small=0x9000000.
- Identical operands -> sw=0, diff=0, small=big.
- Backpressure: out_ready low 4 cycles while 3 pairs are offered back-to-back ->
  - 2 pairs accepted, then in_ready=0
  - out fields held stable
  - after out_ready rises, all 3 results emerge in order, no gaps at full rate.
- rst_n pulsed low with 2 pairs in flight -> out_valid=0 immediately, outputs 0, no stale result after release; next pair has 2-cycle latency.
